// File: rtl/pulp_cluster_package.sv
// Cluster-level constants shared by the EOC/fetch-enable controller:
// peripheral slot index, register byte offsets and a byte-enable helper.
// Optional feature macro used by the controller: CLUSTER_EOC_IRQ_EN.
package pulp_cluster_package;

    // Slave slot of the EOC controller on the peripheral interconnect
    localparam int unsigned SPER_EOC_ID = 0;

    // Register byte offsets inside the EOC controller window
    localparam logic [31:0] EOC_REG_EOC       = 32'h00;
    localparam logic [31:0] EOC_REG_FETCH_EN  = 32'h04;
    localparam logic [31:0] EOC_REG_FETCH_SET = 32'h08;
    localparam logic [31:0] EOC_REG_FETCH_CLR = 32'h0C;
    localparam logic [31:0] EOC_REG_BUSY      = 32'h10;
    localparam logic [31:0] EOC_REG_IDLE_CNT  = 32'h14;
    localparam logic [31:0] EOC_REG_IRQ_MASK  = 32'h18;

    // Expand 4 byte enables into a 32-bit bit mask
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/cluster_eoc_idle_cnt.sv
// Saturating idle-cycle counter: counts cycles with every core idle,
// restarts from zero once any core is busy or software clears it.
module cluster_eoc_idle_cnt #(
    parameter int NB_CORES = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NB_CORES-1:0] core_busy_i,
    input  logic                clr_i,
    output logic [31:0]         cnt_o
);

    logic [31:0] r_cnt;

    // Busy or clear wins over increment; hold at all-ones once saturated
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                   r_cnt <= '0;
        else if (|core_busy_i || clr_i) r_cnt <= '0;
        else if (r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/cluster_eoc_ctrl.sv
// End-of-computation / fetch-enable controller on the peripheral bus.
// Always grants, answers one cycle later. Optional macro CLUSTER_EOC_IRQ_EN
// adds IRQ_MASK at 0x18 and an eoc_irq_o pulse on EOC rising edges.
module cluster_eoc_ctrl
    import pulp_cluster_package::*;
#(
    parameter int NB_CORES = 8,
    parameter int ID_WIDTH = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                speriph_req_i,
    input  logic [31:0]         speriph_add_i,
    input  logic                speriph_wen_i,
    input  logic [31:0]         speriph_wdata_i,
    input  logic [3:0]          speriph_be_i,
    input  logic [ID_WIDTH-1:0] speriph_id_i,
    output logic                speriph_gnt_o,
    output logic                speriph_r_valid_o,
    output logic [31:0]         speriph_r_rdata_o,
    output logic                speriph_r_opc_o,
    output logic [ID_WIDTH-1:0] speriph_r_id_o,
    input  logic [NB_CORES-1:0] core_busy_i,
    output logic [NB_CORES-1:0] fetch_en_o,
    output logic                eoc_o
`ifdef CLUSTER_EOC_IRQ_EN
   ,output logic                eoc_irq_o
`endif
);

    localparam logic [2:0] IDX_EOC  = EOC_REG_EOC[4:2];
    localparam logic [2:0] IDX_FEN  = EOC_REG_FETCH_EN[4:2];
    localparam logic [2:0] IDX_FSET = EOC_REG_FETCH_SET[4:2];
    localparam logic [2:0] IDX_FCLR = EOC_REG_FETCH_CLR[4:2];
    localparam logic [2:0] IDX_BUSY = EOC_REG_BUSY[4:2];
    localparam logic [2:0] IDX_IDLE = EOC_REG_IDLE_CNT[4:2];
`ifdef CLUSTER_EOC_IRQ_EN
    localparam logic [2:0] IDX_IRQM = EOC_REG_IRQ_MASK[4:2];
`endif

    logic                r_eoc;
    logic [NB_CORES-1:0] r_fetch;
    logic [NB_CORES-1:0] r_busy;
    logic                r_valid;
    logic [31:0]         r_rdata;
    logic                r_opc;
    logic [ID_WIDTH-1:0] r_id;

    logic [2:0]          w_idx;
    logic [31:0]         w_bem;
    logic [31:0]         w_wmask;
    logic                w_wr;
    logic                w_err;
    logic [31:0]         w_rd_val;
    logic                w_eoc_nxt;
    logic [NB_CORES-1:0] w_fetch_nxt;
    logic                w_idle_clr;
    logic [31:0]         w_idle_cnt;
    logic                w_unused;

    assign w_idx    = speriph_add_i[4:2];
    assign w_bem    = be_to_mask(speriph_be_i);
    assign w_wmask  = speriph_wdata_i & w_bem;
    assign w_wr     = speriph_req_i & ~speriph_wen_i;
    assign w_unused = ^{speriph_add_i[31:5], speriph_add_i[1:0]};

`ifdef CLUSTER_EOC_IRQ_EN
    logic r_irq_mask;
    logic r_irq;
    logic w_mask_nxt;
`endif

    // Register decode: read mux, error flag and next values of writable state
    always_comb begin
        w_err       = 1'b0;
        w_rd_val    = '0;
        w_eoc_nxt   = r_eoc;
        w_fetch_nxt = r_fetch;
        w_idle_clr  = 1'b0;
`ifdef CLUSTER_EOC_IRQ_EN
        w_mask_nxt  = r_irq_mask;
`endif
        case (w_idx)
            IDX_EOC: begin
                w_rd_val = {31'b0, r_eoc};
                if (w_wr && speriph_be_i[0]) w_eoc_nxt = speriph_wdata_i[0];
            end
            IDX_FEN: begin
                w_rd_val = {{(32-NB_CORES){1'b0}}, r_fetch};
                if (w_wr) w_fetch_nxt = (r_fetch & ~w_bem[NB_CORES-1:0]) | w_wmask[NB_CORES-1:0];
            end
            IDX_FSET: begin
                w_rd_val = {{(32-NB_CORES){1'b0}}, r_fetch};
                if (w_wr) w_fetch_nxt = r_fetch | w_wmask[NB_CORES-1:0];
            end
            IDX_FCLR: begin
                w_rd_val = {{(32-NB_CORES){1'b0}}, r_fetch};
                if (w_wr) w_fetch_nxt = r_fetch & ~w_wmask[NB_CORES-1:0];
            end
            IDX_BUSY: begin
                w_rd_val = {{(32-NB_CORES){1'b0}}, r_busy};
                if (!speriph_wen_i) w_err = 1'b1;
            end
            IDX_IDLE: begin
                w_rd_val = w_idle_cnt;
                if (w_wr) w_idle_clr = 1'b1;
            end
`ifdef CLUSTER_EOC_IRQ_EN
            IDX_IRQM: begin
                w_rd_val = {31'b0, r_irq_mask};
                if (w_wr && speriph_be_i[0]) w_mask_nxt = speriph_wdata_i[0];
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    // Control/status registers; updates land together with the response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_eoc   <= 1'b0;
            r_fetch <= '0;
            r_busy  <= '0;
        end else begin
            r_eoc   <= w_eoc_nxt;
            r_fetch <= w_fetch_nxt;
            r_busy  <= core_busy_i;
        end
    end

    // Response channel: one registered response per granted request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_opc   <= 1'b0;
            r_id    <= '0;
        end else begin
            r_valid <= speriph_req_i;
            if (speriph_req_i) begin
                r_id    <= speriph_id_i;
                r_opc   <= w_err;
                r_rdata <= (speriph_wen_i && !w_err) ? w_rd_val : 32'h0;
            end
        end
    end

`ifdef CLUSTER_EOC_IRQ_EN
    // Interrupt mask and one-cycle pulse on EOC rising edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_mask <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_mask <= w_mask_nxt;
            r_irq      <= w_eoc_nxt & ~r_eoc & r_irq_mask;
        end
    end
    assign eoc_irq_o = r_irq;
`endif

    cluster_eoc_idle_cnt #(
        .NB_CORES (NB_CORES)
    ) u_idle (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .core_busy_i (core_busy_i),
        .clr_i       (w_idle_clr),
        .cnt_o       (w_idle_cnt)
    );

    assign speriph_gnt_o     = speriph_req_i;
    assign speriph_r_valid_o = r_valid;
    assign speriph_r_rdata_o = r_rdata;
    assign speriph_r_opc_o   = r_opc;
    assign speriph_r_id_o    = r_id;
    assign fetch_en_o        = r_fetch;
    assign eoc_o             = r_eoc;

endmodule

// File: tb/tb_cluster_eoc_ctrl.sv
// Self-checking bench for cluster_eoc_ctrl: directed register scenarios
// plus randomized traffic compared against a register-map model.
module tb_cluster_eoc_ctrl;
    localparam int NB = 8;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req, wen;
    logic [31:0]   add, wdata;
    logic [3:0]    be;
    logic [IW-1:0] id;
    logic          gnt, r_valid, r_opc;
    logic [31:0]   r_rdata;
    logic [IW-1:0] r_id;
    logic [NB-1:0] busy, fetch_en;
    logic          eoc;
`ifdef CLUSTER_EOC_IRQ_EN
    logic          eoc_irq;
`endif

    cluster_eoc_ctrl #(.NB_CORES(NB), .ID_WIDTH(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .speriph_req_i(req), .speriph_add_i(add), .speriph_wen_i(wen),
        .speriph_wdata_i(wdata), .speriph_be_i(be), .speriph_id_i(id),
        .speriph_gnt_o(gnt), .speriph_r_valid_o(r_valid),
        .speriph_r_rdata_o(r_rdata), .speriph_r_opc_o(r_opc),
        .speriph_r_id_o(r_id), .core_busy_i(busy),
        .fetch_en_o(fetch_en), .eoc_o(eoc)
`ifdef CLUSTER_EOC_IRQ_EN
       ,.eoc_irq_o(eoc_irq)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [31:0] FM = (32'h1 << NB) - 32'h1;
    logic [31:0]   m_eoc = 0, m_fetch = 0, m_busy = 0, m_idle = 0, m_irqm = 0;
    logic          e_valid = 0, e_opc = 0, e_irq = 0;
    logic [31:0]   e_rdata = 0;
    logic [IW-1:0] e_id = 0;
    logic          sat_req = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_eoc <= 0; m_fetch <= 0; m_busy <= 0; m_idle <= 0; m_irqm <= 0;
            e_valid <= 0; e_opc <= 0; e_irq <= 0; e_rdata <= 0; e_id <= 0;
        end else begin
            logic [31:0] bem, wm, base, rd, nfetch, nidle, neoc, nmask;
            logic err, clr, wr;
            base = sat_req ? 32'hFFFF_FFFF : m_idle;
            bem  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            wm   = wdata & bem;
            neoc = m_eoc; nfetch = m_fetch; nmask = m_irqm;
            clr = 0; err = 0; rd = 0; wr = req && !wen;
            if (gnt !== req) chk("gnt", {31'b0, gnt}, {31'b0, req});
            if (req) begin
                case (add[4:2])
                    3'd0: begin rd = m_eoc; if (wr && be[0]) neoc = {31'b0, wdata[0]}; end
                    3'd1: begin rd = m_fetch; if (wr) nfetch = ((m_fetch & ~bem) | wm) & FM; end
                    3'd2: begin rd = m_fetch; if (wr) nfetch = (m_fetch | wm) & FM; end
                    3'd3: begin rd = m_fetch; if (wr) nfetch = m_fetch & ~wm; end
                    3'd4: begin rd = m_busy; if (wr) err = 1; end
                    3'd5: begin rd = base; if (wr) clr = 1; end
`ifdef CLUSTER_EOC_IRQ_EN
                    3'd6: begin rd = m_irqm; if (wr && be[0]) nmask = {31'b0, wdata[0]}; end
`endif
                    default: err = 1;
                endcase
                e_valid <= 1; e_id <= id; e_opc <= err;
                e_rdata <= (wen && !err) ? rd : 32'h0;
            end else e_valid <= 0;
            if (busy != 0 || clr)           nidle = 0;
            else if (base == 32'hFFFF_FFFF) nidle = base;
            else                            nidle = base + 1;
            e_irq   <= neoc[0] && !m_eoc[0] && m_irqm[0];
            m_busy  <= {24'b0, busy};
            m_eoc   <= neoc; m_fetch <= nfetch; m_irqm <= nmask; m_idle <= nidle;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        chk("r_valid", {31'b0, r_valid}, {31'b0, e_valid});
        if (e_valid && r_valid) begin
            chk("r_id", {27'b0, r_id}, {27'b0, e_id});
            chk("r_opc", {31'b0, r_opc}, {31'b0, e_opc});
            chk("r_rdata", r_rdata, e_rdata);
        end
        chk("fetch_en_o", {24'b0, fetch_en}, m_fetch);
        chk("eoc_o", {31'b0, eoc}, m_eoc);
`ifdef CLUSTER_EOC_IRQ_EN
        chk("eoc_irq_o", {31'b0, eoc_irq}, {31'b0, e_irq});
`endif
    end

    // ---------------- stimulus ----------------
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [IW-1:0] i);
        req = 1; wen = w; add = a; wdata = d; be = b; id = i;
        @(negedge clk);
        req = 0;
    endtask

    int irq_cnt = 0;
`ifdef CLUSTER_EOC_IRQ_EN
    always @(negedge clk) if (eoc_irq) irq_cnt++;
`endif

    initial begin
        logic [31:0] r;
        rst_n = 1; req = 0; wen = 1; add = 0; wdata = 0; be = 0; id = 0; busy = 0;
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("reset eoc", {31'b0, eoc}, 32'h0);
        chk("reset fetch", {24'b0, fetch_en}, 32'h0);
        chk("reset valid", {31'b0, r_valid}, 32'h0);
        chk("reset rdata", r_rdata, 32'h0);
        rst_n = 1;
        @(negedge clk);

        // FETCH_EN write/read
        xact(0, 32'h04, 32'h0000_00A5, 4'hF, 1);
        chk("fetch write A5", {24'b0, fetch_en}, 32'hA5);
        xact(1, 32'h04, 32'h0, 4'h0, 2);
        chk("fetch read data", r_rdata, 32'hA5);
        chk("fetch read opc", {31'b0, r_opc}, 32'h0);

        // set / clear
        xact(0, 32'h08, 32'h02, 4'hF, 3);
        chk("fetch set", {24'b0, fetch_en}, 32'hA7);
        xact(0, 32'h0C, 32'h80, 4'hF, 4);
        chk("fetch clr", {24'b0, fetch_en}, 32'h27);

        // back-to-back reads
        req = 1; wen = 1; add = 32'h04; be = 4'hF; id = 3;
        @(negedge clk); chk("b2b valid0", {31'b0, r_valid}, 1); chk("b2b id0", {27'b0, r_id}, 3); id = 4;
        @(negedge clk); chk("b2b valid1", {31'b0, r_valid}, 1); chk("b2b id1", {27'b0, r_id}, 4); id = 5;
        @(negedge clk); chk("b2b valid2", {31'b0, r_valid}, 1); chk("b2b id2", {27'b0, r_id}, 5); req = 0;

        // errors
        xact(1, 32'h1C, 32'h0, 4'hF, 6);
        chk("unmapped opc", {31'b0, r_opc}, 1);
        chk("unmapped rdata", r_rdata, 0);
        busy = 8'h5A;
        @(negedge clk);
        xact(0, 32'h10, 32'hFFFF_FFFF, 4'hF, 7);
        chk("busy write opc", {31'b0, r_opc}, 1);
        xact(1, 32'h10, 32'h0, 4'hF, 8);
        chk("busy read", r_rdata, 32'h5A);

        // idle counter
        busy = 8'h01; @(negedge clk); busy = 0;
        repeat (10) @(negedge clk);
        xact(1, 32'h14, 32'h0, 4'hF, 9);
        chk("idle 10", r_rdata, 32'd10);
        busy = 8'h01; @(negedge clk);
        xact(1, 32'h14, 32'h0, 4'hF, 10);
        chk("idle cleared", r_rdata, 32'd0);
        busy = 0;
        force dut.u_idle.r_cnt = 32'hFFFF_FFFF;
        sat_req = 1;
        #1 release dut.u_idle.r_cnt;
        @(negedge clk); sat_req = 0;
        repeat (2) @(negedge clk);
        xact(1, 32'h14, 32'h0, 4'hF, 11);
        chk("idle saturated", r_rdata, 32'hFFFF_FFFF);

`ifdef CLUSTER_EOC_IRQ_EN
        xact(0, 32'h18, 32'h1, 4'hF, 12);
        xact(0, 32'h00, 32'h0, 4'hF, 13);
        @(negedge clk);
        irq_cnt = 0;
        xact(0, 32'h00, 32'h1, 4'hF, 14);
        xact(0, 32'h00, 32'h1, 4'hF, 15);
        repeat (3) @(negedge clk);
        chk("irq single pulse", irq_cnt, 1);
        chk("eoc set", {31'b0, eoc}, 1);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r     = $urandom;
            req   = ($urandom % 3) != 0;
            wen   = $urandom % 2;
            add   = {r[31:5], 3'($urandom_range(0, 7)), r[1:0]};
            wdata = $urandom;
            be    = 4'($urandom);
            id    = IW'($urandom);
            busy  = (($urandom % 4) == 0) ? NB'($urandom) : '0;
            @(negedge clk);
        end
        req = 0; busy = 0;
        @(negedge clk);

        // reset in the middle of a read
        req = 1; wen = 1; add = 32'h04; id = 9;
        @(posedge clk); #1;
        rst_n = 0; req = 0;
        #1 chk("reset mid-read valid", {31'b0, r_valid}, 0);
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no response after reset", {31'b0, r_valid}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
